// File: rtl/perf_sample_ctrl_pkg.sv
// Shared types and constants for the performance-counter sampler.
// Holds the sample record layout, the sweep FSM states and the counter CSR address bases.
package perf_sample_ctrl_pkg;

    localparam logic [11:0] CsrMhpmCounter3  = 12'hB03;
    localparam logic [11:0] CsrMhpmCounter3H = 12'hB83;

    typedef struct packed {
        logic [7:0]  sweep_id;
        logic [4:0]  idx;
        logic [63:0] value;
    } hpm_sample_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StSweep
    } sweep_state_e;

    function automatic logic [11:0] counter_addr(input logic [4:0] idx, input logic high);
        return (high ? CsrMhpmCounter3H : CsrMhpmCounter3) + 12'(idx);
    endfunction

endpackage

// File: rtl/perf_sample_ctrl_fifo.sv
// Registered-output sample FIFO (no fall-through); Depth must be a power of two, at least 2.
// The full flag is exact, so a push into a full FIFO is dropped even when a pop happens.
module perf_sample_ctrl_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] data_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic [Width-1:0] mem_q [Depth];
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AddrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (AddrW + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - (AddrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/perf_sample_ctrl.sv
// Periodic sweep sampler for the generic HPM counters, sharing the counter port with the CSR
// regfile (CSR always wins) and queueing records for the debug/trace consumer.
module perf_sample_ctrl
    import perf_sample_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned NumCounters = 6,
    parameter int unsigned FifoDepth   = 8,
    parameter int unsigned PeriodWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   csr_req_i,
    input  logic [11:0]            csr_addr_i,
    input  logic                   csr_we_i,
    input  logic [XLEN-1:0]        csr_wdata_i,
    output logic [XLEN-1:0]        csr_rdata_o,
    output logic [11:0]            pc_addr_o,
    output logic                   pc_we_o,
    output logic [XLEN-1:0]        pc_data_o,
    input  logic [XLEN-1:0]        pc_data_i,
    input  logic                   enable_i,
    input  logic                   debug_mode_i,
    input  logic [PeriodWidth-1:0] period_i,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output hpm_sample_t            sample_o,
    output logic [15:0]            missed_o,
    output logic                   busy_o
);

    // On a 32-bit datapath each counter takes a low-word read then a high-word read.
    localparam bit         Split   = (XLEN == 32);
    localparam logic [4:0] LastIdx = 5'(NumCounters - 1);

    sweep_state_e           state_q, state_d;
    logic [PeriodWidth-1:0] timer_q, timer_d;
    logic [4:0]             idx_q, idx_d;
    logic                   half_q, half_d;
    logic [31:0]            lo_q, lo_d;
    logic [7:0]             sweep_id_q, sweep_id_d;
    logic [15:0]            missed_q, missed_d;

    logic        fifo_full, fifo_empty, push, abort, rd_ok, final_rd;
    logic [63:0] rd_value;
    hpm_sample_t push_data;

    assign abort    = !enable_i || debug_mode_i;
    assign rd_ok    = !csr_req_i && !fifo_full;
    assign final_rd = !Split || half_q;

    always_comb begin
        if (Split) begin
            rd_value = {pc_data_i[31:0], lo_q};
        end else begin
            rd_value = 64'(pc_data_i);
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        half_d     = half_q;
        lo_d       = lo_q;
        sweep_id_d = sweep_id_q;
        missed_d   = missed_q;
        push       = 1'b0;

        if (abort) begin
            // Any half-assembled record is dropped; queued records stay in the FIFO.
            state_d = StIdle;
            idx_d   = '0;
            half_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timer_d = period_i;
                    state_d = StWait;
                end
                StWait: begin
                    if (timer_q == '0) begin
                        timer_d = period_i;
                        idx_d   = '0;
                        half_d  = 1'b0;
                        state_d = StSweep;
                    end else begin
                        timer_d = timer_q - PeriodWidth'(1);
                    end
                end
                StSweep: begin
                    // An expiry mid-sweep is only counted; no extra sweep is queued.
                    if (timer_q == '0) begin
                        timer_d = period_i;
                        if (missed_q != '1) missed_d = missed_q + 16'd1;
                    end else begin
                        timer_d = timer_q - PeriodWidth'(1);
                    end
                    if (rd_ok) begin
                        if (!final_rd) begin
                            lo_d   = pc_data_i[31:0];
                            half_d = 1'b1;
                        end else begin
                            push   = 1'b1;
                            half_d = 1'b0;
                            if (idx_q == LastIdx) begin
                                idx_d      = '0;
                                sweep_id_d = sweep_id_q + 8'd1;
                                state_d    = StWait;
                            end else begin
                                idx_d = idx_q + 5'd1;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            idx_q      <= '0;
            half_q     <= 1'b0;
            lo_q       <= '0;
            sweep_id_q <= '0;
            missed_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            half_q     <= half_d;
            lo_q       <= lo_d;
            sweep_id_q <= sweep_id_d;
            missed_q   <= missed_d;
        end
    end

    always_comb begin
        if (csr_req_i) begin
            pc_addr_o = csr_addr_i;
            pc_we_o   = csr_we_i;
            pc_data_o = csr_wdata_i;
        end else begin
            pc_addr_o = (state_q == StSweep) ? counter_addr(idx_q, half_q) : 12'h000;
            pc_we_o   = 1'b0;
            pc_data_o = '0;
        end
    end

    assign csr_rdata_o = pc_data_i;
    assign busy_o      = (state_q == StSweep);
    assign missed_o    = missed_q;

    assign push_data.sweep_id = sweep_id_q;
    assign push_data.idx      = idx_q;
    assign push_data.value    = rd_value;

    assign sample_valid_o = !fifo_empty;

    perf_sample_ctrl_fifo #(
        .Width ($bits(hpm_sample_t)),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (sample_valid_o && sample_ready_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (sample_o)
    );

endmodule

// File: tb/tb_perf_sample_ctrl.sv
// Self-checking bench: a 64-bit instance (FifoDepth 4) and a 32-bit instance (FifoDepth 8),
// each reading from a small counter-array model; records are compared through queues.
module tb_perf_sample_ctrl;
    import perf_sample_ctrl_pkg::*;

    localparam int NC = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // 64-bit instance
    logic        csr_req, csr_we, enable, debug, ready, valid, busy, pc_we;
    logic [11:0] csr_addr, pc_addr;
    logic [63:0] csr_wdata, csr_rdata, pc_wdata, pc_rdata;
    logic [31:0] period;
    logic [15:0] missed;
    hpm_sample_t sample;
    logic [63:0] cnt64 [NC];

    // 32-bit instance
    logic        csr_req32, csr_we32, enable32, ready32, valid32, busy32, pc_we32;
    logic [11:0] csr_addr32, pc_addr32;
    logic [31:0] csr_wdata32, csr_rdata32, pc_wdata32, pc_rdata32;
    logic [15:0] missed32;
    hpm_sample_t sample32;
    logic [63:0] cnt32 [NC];

    hpm_sample_t exp64[$], obs64[$], exp32[$], obs32[$];
    int          obsc64[$], obsc32[$];
    logic [11:0] alog32[$];
    logic [7:0]  sid64 = 8'd0;

    perf_sample_ctrl #(
        .XLEN (64), .NumCounters (NC), .FifoDepth (4), .PeriodWidth (32)
    ) dut64 (
        .clk_i (clk), .rst_ni (rst_n),
        .csr_req_i (csr_req), .csr_addr_i (csr_addr), .csr_we_i (csr_we),
        .csr_wdata_i (csr_wdata), .csr_rdata_o (csr_rdata),
        .pc_addr_o (pc_addr), .pc_we_o (pc_we), .pc_data_o (pc_wdata), .pc_data_i (pc_rdata),
        .enable_i (enable), .debug_mode_i (debug), .period_i (period),
        .sample_valid_o (valid), .sample_ready_i (ready), .sample_o (sample),
        .missed_o (missed), .busy_o (busy)
    );

    perf_sample_ctrl #(
        .XLEN (32), .NumCounters (NC), .FifoDepth (8), .PeriodWidth (32)
    ) dut32 (
        .clk_i (clk), .rst_ni (rst_n),
        .csr_req_i (csr_req32), .csr_addr_i (csr_addr32), .csr_we_i (csr_we32),
        .csr_wdata_i (csr_wdata32), .csr_rdata_o (csr_rdata32),
        .pc_addr_o (pc_addr32), .pc_we_o (pc_we32), .pc_data_o (pc_wdata32),
        .pc_data_i (pc_rdata32),
        .enable_i (enable32), .debug_mode_i (1'b0), .period_i (period),
        .sample_valid_o (valid32), .sample_ready_i (ready32), .sample_o (sample32),
        .missed_o (missed32), .busy_o (busy32)
    );

    always_comb begin
        int a;
        pc_rdata = '0;
        a = int'(pc_addr) - int'(12'hB03);
        if (a >= 0 && a < NC) pc_rdata = cnt64[a];
    end

    always_comb begin
        int a;
        pc_rdata32 = '0;
        a = int'(pc_addr32) - int'(12'hB03);
        if (a >= 0 && a < NC) pc_rdata32 = cnt32[a][31:0];
        a = int'(pc_addr32) - int'(12'hB83);
        if (a >= 0 && a < NC) pc_rdata32 = cnt32[a][63:32];
    end

    always @(negedge clk) begin
        if (valid && ready) begin
            obs64.push_back(sample);
            obsc64.push_back(cyc);
        end
        if (valid32 && ready32) begin
            obs32.push_back(sample32);
            obsc32.push_back(cyc);
        end
        if (busy32 && alog32.size() < 2) alog32.push_back(pc_addr32);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input bit w32, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = w32 ? (obs32.size() >= n) : (obs64.size() >= n);
        end
    endtask

    task automatic push_sweep64(input int first, input int last, input logic [7:0] sid);
        hpm_sample_t e;
        for (int i = first; i <= last; i++) begin
            e.sweep_id = sid;
            e.idx      = 5'(i);
            e.value    = cnt64[i];
            exp64.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || missed !== 16'h0 || pc_addr !== 12'h0 ||
            pc_we !== 1'b0 || pc_wdata !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b valid=%b missed=%h addr=%h we=%b data=%h, want all 0",
                     busy, valid, missed, pc_addr, pc_we, pc_wdata);
        end
        rst_n = 1'b1;
        step(3);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || valid32 !== 1'b0 || pc_addr !== 12'h0) begin
            failures++;
            $display("FAIL post_reset_idle: busy=%b valid=%b valid32=%b addr=%h, want 0",
                     busy, valid, valid32, pc_addr);
        end
    endtask

    task automatic test_csr_passthrough();
        csr_req = 1'b1; csr_we = 1'b1; csr_addr = 12'hB05; csr_wdata = 64'hDEAD_BEEF_0123_4567;
        #1;
        checks++;
        if (pc_addr !== 12'hB05 || pc_we !== 1'b1 || pc_wdata !== 64'hDEAD_BEEF_0123_4567) begin
            failures++;
            $display("FAIL csr_write: addr=%h we=%b data=%h, want B05 1 deadbeef01234567",
                     pc_addr, pc_we, pc_wdata);
        end
        csr_we = 1'b0;
        #1;
        checks++;
        if (pc_we !== 1'b0 || csr_rdata !== cnt64[2]) begin
            failures++;
            $display("FAIL csr_read: we=%b rdata=%h, want 0 %h", pc_we, csr_rdata, cnt64[2]);
        end
        csr_req = 1'b0;
        #1;
        checks++;
        if (pc_addr !== 12'h0 || pc_wdata !== 64'h0) begin
            failures++;
            $display("FAIL idle_port: addr=%h data=%h, want 0 0", pc_addr, pc_wdata);
        end
    endtask

    task automatic test_periodic();
        hpm_sample_t e, o;
        int c[$];
        bit ok;
        obs64.delete(); obsc64.delete();
        period = 32'd20; ready = 1'b1;
        push_sweep64(0, NC - 1, sid64);
        push_sweep64(0, NC - 1, sid64 + 8'd1);
        enable = 1'b1;
        wait_count(1'b0, 2 * NC, 200, ok);
        enable = 1'b0;
        sid64 += 8'd2;
        c = obsc64;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL periodic_count: got %0d records, want %0d", obs64.size(), 2 * NC);
        end
        while (exp64.size() > 0) begin
            e = exp64.pop_front();
            if (obs64.size() > 0) begin
                o = obs64.pop_front();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL periodic_rec: got id=%0d idx=%0d val=%0d, want id=%0d idx=%0d val=%0d",
                             o.sweep_id, o.idx, o.value, e.sweep_id, e.idx, e.value);
                end
            end
        end
        if (c.size() >= 2 * NC) begin
            checks++;
            if (c[NC] - c[0] != 21 || c[NC-1] - c[0] != NC - 1) begin
                failures++;
                $display("FAIL periodic_timing: sweep gap=%0d span=%0d, want 21 %0d",
                         c[NC] - c[0], c[NC-1] - c[0], NC - 1);
            end
        end
    endtask

    task automatic test_csr_overlap();
        hpm_sample_t e, o;
        int c[$];
        bit ok, found;
        obs64.delete(); obsc64.delete();
        period = 32'd20; ready = 1'b1;
        push_sweep64(0, NC - 1, sid64);
        enable = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (busy && pc_addr == 12'hB04 && !csr_req) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL overlap_find: idx1 read not seen, got found=%b want 1", found);
        end
        step(1);
        csr_req = 1'b1; csr_we = 1'b0; csr_addr = 12'hB04;
        @(negedge clk);
        checks++;
        if (csr_rdata !== cnt64[1] || pc_addr !== 12'hB04 || pc_we !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL overlap_csr: rdata=%0d addr=%h we=%b busy=%b, want %0d B04 0 1",
                     csr_rdata, pc_addr, pc_we, busy, cnt64[1]);
        end
        step(1);
        csr_req = 1'b0;
        wait_count(1'b0, NC, 100, ok);
        enable = 1'b0;
        sid64 += 8'd1;
        c = obsc64;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL overlap_count: got %0d records, want %0d", obs64.size(), NC);
        end
        while (exp64.size() > 0) begin
            e = exp64.pop_front();
            if (obs64.size() > 0) begin
                o = obs64.pop_front();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL overlap_rec: got id=%0d idx=%0d val=%0d, want id=%0d idx=%0d val=%0d",
                             o.sweep_id, o.idx, o.value, e.sweep_id, e.idx, e.value);
                end
            end
        end
        if (c.size() >= NC) begin
            checks++;
            if (c[2] - c[1] != 2 || c[5] - c[2] != 3) begin
                failures++;
                $display("FAIL overlap_stall: gaps %0d %0d, want 2 3", c[2] - c[1], c[5] - c[2]);
            end
        end
        step(3);
    endtask

    task automatic test_backpressure();
        hpm_sample_t e, o;
        bit ok, seen;
        obs64.delete(); obsc64.delete();
        period = 32'd20; ready = 1'b0;
        push_sweep64(0, NC - 1, sid64);
        enable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = busy;
        end
        step(30);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b1 || obs64.size() != 0) begin
            failures++;
            $display("FAIL bp_hold: busy=%b valid=%b popped=%0d, want 1 1 0",
                     busy, valid, obs64.size());
        end
        step(1);
        ready = 1'b1;
        wait_count(1'b0, NC, 60, ok);
        enable = 1'b0;
        sid64 += 8'd1;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_count: got %0d records, want %0d", obs64.size(), NC);
        end
        while (exp64.size() > 0) begin
            e = exp64.pop_front();
            if (obs64.size() > 0) begin
                o = obs64.pop_front();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL bp_rec: got id=%0d idx=%0d val=%0d, want id=%0d idx=%0d val=%0d",
                             o.sweep_id, o.idx, o.value, e.sweep_id, e.idx, e.value);
                end
            end
        end
        step(3);
    endtask

    task automatic test_missed_abort();
        hpm_sample_t e, o;
        logic [15:0] m0, m1;
        bit ok;
        obs64.delete(); obsc64.delete();
        period = 32'd2; ready = 1'b0;
        enable = 1'b1;
        step(20);
        @(negedge clk);
        m0 = missed;
        repeat (30) @(negedge clk);
        m1 = missed;
        checks++;
        if (m1 - m0 != 16'd10 || busy !== 1'b1) begin
            failures++;
            $display("FAIL missed_rate: delta=%0d busy=%b, want 10 1", m1 - m0, busy);
        end
        // Aborting mid-stall keeps the four queued records and does not bump the sweep id.
        step(1);
        enable = 1'b0;
        push_sweep64(0, 3, sid64);
        step(2);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_keep: busy=%b valid=%b, want 0 1", busy, valid);
        end
        ready = 1'b1;
        wait_count(1'b0, 4, 30, ok);
        step(10);
        checks++;
        if (!ok || obs64.size() != 4) begin
            failures++;
            $display("FAIL abort_count: got %0d records, want 4", obs64.size());
        end
        while (exp64.size() > 0) begin
            e = exp64.pop_front();
            if (obs64.size() > 0) begin
                o = obs64.pop_front();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL abort_rec: got id=%0d idx=%0d val=%0d, want id=%0d idx=%0d val=%0d",
                             o.sweep_id, o.idx, o.value, e.sweep_id, e.idx, e.value);
                end
            end
        end
    endtask

    task automatic test_drop_after_idx2();
        hpm_sample_t e, o;
        bit ok, found;
        obs64.delete(); obsc64.delete();
        period = 32'd20; ready = 1'b0;
        push_sweep64(0, 2, sid64);
        enable = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (busy && pc_addr == 12'hB05) found = 1'b1;
        end
        step(1);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!found || busy !== 1'b0 || valid !== 1'b1) begin
            failures++;
            $display("FAIL drop_idle: found=%b busy=%b valid=%b, want 1 0 1", found, busy, valid);
        end
        step(1);
        ready = 1'b1;
        wait_count(1'b0, 3, 30, ok);
        step(10);
        checks++;
        if (!ok || obs64.size() != 3) begin
            failures++;
            $display("FAIL drop_count: got %0d records, want 3", obs64.size());
        end
        while (exp64.size() > 0) begin
            e = exp64.pop_front();
            if (obs64.size() > 0) begin
                o = obs64.pop_front();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL drop_rec: got id=%0d idx=%0d val=%0d, want id=%0d idx=%0d val=%0d",
                             o.sweep_id, o.idx, o.value, e.sweep_id, e.idx, e.value);
                end
            end
        end
    endtask

    task automatic test_debug_pause();
        bit any_busy;
        obs64.delete(); obsc64.delete();
        period = 32'd2; ready = 1'b1; debug = 1'b1; enable = 1'b1;
        any_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) any_busy = 1'b1;
        end
        checks++;
        if (any_busy || obs64.size() != 0) begin
            failures++;
            $display("FAIL debug_pause: busy_seen=%b records=%0d, want 0 0", any_busy, obs64.size());
        end
        step(1);
        enable = 1'b0; debug = 1'b0;
        step(2);
    endtask

    task automatic test_xlen32();
        hpm_sample_t e, o;
        int c[$];
        bit ok;
        obs32.delete(); obsc32.delete(); alog32.delete();
        period = 32'd20; ready32 = 1'b1;
        for (int i = 0; i < NC; i++) begin
            e.sweep_id = 8'd0;
            e.idx      = 5'(i);
            e.value    = cnt32[i];
            exp32.push_back(e);
        end
        enable32 = 1'b1;
        wait_count(1'b1, NC, 200, ok);
        enable32 = 1'b0;
        c = obsc32;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL x32_count: got %0d records, want %0d", obs32.size(), NC);
        end
        checks++;
        if (alog32.size() < 2 || alog32[0] !== 12'hB03 || alog32[1] !== 12'hB83) begin
            failures++;
            $display("FAIL x32_addr: got %0d addrs first=%h, want B03 then B83",
                     alog32.size(), (alog32.size() > 0) ? alog32[0] : 12'h0);
        end
        while (exp32.size() > 0) begin
            e = exp32.pop_front();
            if (obs32.size() > 0) begin
                o = obs32.pop_front();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL x32_rec: got id=%0d idx=%0d val=%h, want id=%0d idx=%0d val=%h",
                             o.sweep_id, o.idx, o.value, e.sweep_id, e.idx, e.value);
                end
            end
        end
        if (c.size() >= NC) begin
            checks++;
            if (c[1] - c[0] != 2 || c[NC-1] - c[0] != 2 * (NC - 1)) begin
                failures++;
                $display("FAIL x32_timing: gap=%0d span=%0d, want 2 %0d",
                         c[1] - c[0], c[NC-1] - c[0], 2 * (NC - 1));
            end
        end
    endtask

    task automatic test_saturate();
        period = 32'd0; ready = 1'b0; enable = 1'b1;
        step(65600);
        @(negedge clk);
        checks++;
        if (missed !== 16'hFFFF) begin
            failures++;
            $display("FAIL missed_sat: got %h, want FFFF", missed);
        end
        step(5);
        @(negedge clk);
        checks++;
        if (missed !== 16'hFFFF || busy !== 1'b1) begin
            failures++;
            $display("FAIL missed_hold: missed=%h busy=%b, want FFFF 1", missed, busy);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || missed !== 16'h0 || pc_addr !== 12'h0 ||
            pc_we !== 1'b0 || pc_wdata !== 64'h0) begin
            failures++;
            $display("FAIL async_reset: busy=%b valid=%b missed=%h addr=%h we=%b data=%h, want all 0",
                     busy, valid, missed, pc_addr, pc_we, pc_wdata);
        end
        enable = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        csr_req = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
        enable = 1'b0; debug = 1'b0; ready = 1'b0; period = '0;
        csr_req32 = 1'b0; csr_we32 = 1'b0; csr_addr32 = '0; csr_wdata32 = '0;
        enable32 = 1'b0; ready32 = 1'b0;
        for (int i = 0; i < NC; i++) begin
            cnt64[i] = 64'(100 + i);
            cnt32[i] = 64'hA5A5_0000_0000_0010 + 64'(i) + 64'(i << 40);
        end
        cnt32[0] = 64'h0000_0001_FFFF_FFFF;

        test_reset();
        test_csr_passthrough();
        test_periodic();
        test_csr_overlap();
        test_backpressure();
        test_missed_abort();
        test_drop_after_idx2();
        test_debug_pause();
        test_xlen32();
        test_saturate();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perf_sample_ctrl.md
# perf_sample_ctrl

Periodic sampler and port arbiter for the hardware performance counter block. Shares the counters' SRAM-like CSR port (addr/we/data, combinational read) between the CSR regfile and an internal sweep sequencer. Every programmed period, the sequencer reads all generic counters (mhpmcounter3..) and pushes timestamped-by-sweep records into a FIFO. The FIFO is drained over a valid/ready port by the debug/trace unit.

## Interface
- XLEN, 64, datapath width (32 or 64)
- NumCounters, 6, generic counters swept (mhpmcounter3 .. 3+NumCounters-1)
- FifoDepth, 8, sample FIFO entries (power of two)
- PeriodWidth, 32, width of sampling period
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- csr_req_i  in  1  CSR regfile access to counter port this cycle
- csr_addr_i  in  12  CSR address
- csr_we_i  in  1  CSR write enable
- csr_wdata_i  in  XLEN  CSR write data
- csr_rdata_o  out  XLEN  read data returned to CSR regfile (pc_data_i pass-through)
- pc_addr_o  out  12  address to counter block
- pc_we_o  out  1  write enable to counter block
- pc_data_o  out  XLEN  write data to counter block
- pc_data_i  in  XLEN  combinational read data from counter block
- enable_i  in  1  sampling enable
- debug_mode_i  in  1  core in debug mode: sweeps paused
- period_i  in  PeriodWidth  sweep period in cycles minus one
- sample_valid_o  out  1  FIFO head valid
- sample_ready_i  in  1  consumer accepts head
- sample_o  out  hpm_sample_t  {sweep_id[7:0], idx[4:0], value[63:0]}
- missed_o  out  16  saturating count of period expiries during an active sweep
- busy_o  out  1  state is SWEEP

## Operation
- Arbitration: csr_req_i has absolute priority. While asserted, pc_* = csr_*, and the sequencer issues nothing that cycle. pc_we_o is asserted only for CSR writes; the sequencer never writes.
- When idle, pc_addr_o = sequencer address (or 0 when IDLE/WAIT), pc_we_o=0.
- FSM states:
  - IDLE: enable_i=1 and !debug_mode_i → load timer = period_i, go WAIT.
  - WAIT: timer decrements each cycle; timer==0 → reload, idx=0, half=0, go SWEEP.
  - SWEEP: read counter idx, capture, and push. After idx==NumCounters-1 is pushed → sweep_id++ (wraps 255→0), go WAIT.
- Read addressing:
  - XLEN=64: one read at 12'hB03+idx.
  - XLEN=32: low word at 12'hB03+idx (half=0), then high word at 12'hB83+idx (half=1). The value is assembled from both reads.
- A read is issued only if !csr_req_i and FIFO not full. Otherwise the sequencer stalls on the same idx/half. Push occurs on the cycle of the final read for that counter.
- Timer also runs in SWEEP. At expiry in SWEEP: reload; missed_o++ (saturates at 16'hFFFF); the sweep continues and no new sweep is queued.
- enable_i=0 or debug_mode_i=1 in any state: abort immediately to IDLE. Any half-assembled record is discarded; FIFO contents are kept.
- Pop when sample_valid_o && sample_ready_i.

## Timing
- Capture is in the same cycle as the address (combinational read). The record is visible on sample_valid_o the next cycle.
- Sweep duration, absent stalls: NumCounters cycles (XLEN=64), 2*NumCounters cycles (XLEN=32).
- WAIT→SWEEP: first read the cycle after timer==0.
- Full FIFO: no push, even with a simultaneous pop. Push resumes the cycle after the pop.
- period_i is sampled only at reload. Changes mid-period take effect at the next reload.
- Reset values:
  - state IDLE, timer 0, sweep_id 0, missed_o 0
  - FIFO empty, sample_valid_o 0, busy_o 0
  - pc_addr_o 0, pc_we_o 0, pc_data_o 0

## Structure
- hpm_sample_t and the sweep FSM enum go in ariane_pkg. Counter address bases come from riscv::CSR_MHPM_COUNTER_3 and CSR_MHPM_COUNTER_3H.
- The FIFO is the common_cells fifo_v3 instance (FALL_THROUGH=0, DEPTH=FifoDepth).
- The rest is a single module: FSM, timer, arbiter mux.

## Test plan
- XLEN=64, period_i=20, enable, counters preloaded 100..105, consumer always ready → 6 records, idx 0..5, values 100..105, sweep_id 0, next sweep 21 cycles after first.
- CSR read of 12'hB04 overlapping sweep at idx 2 → csr_rdata_o = counter 4, sweep stalls one cycle, records still in order, no duplicates/loss.
- sample_ready_i=0, FifoDepth=4, NumCounters=6 → 4 records held, busy_o stays 1. Raise ready → remaining 2 pushed, order preserved.
- period_i=2 with stalled consumer → missed_o increments once per expiry in SWEEP, saturates at 16'hFFFF under forced long run.
- XLEN=32, counter 0 = 64'h0000_0001_FFFF_FFFF → record value exact, two reads at 12'hB03 then 12'hB83.
- enable_i dropped mid-sweep (after idx 2) → IDLE next cycle, 3 records remain poppable. Assert rst_ni low mid-sweep → all outputs to reset values asynchronously.
